// File: rtl/slice_pkg.sv
// Shared types and helpers for the LVDS word slicer / frame tracker.
`ifndef SLICE_PKG_SV
`define SLICE_PKG_SV

// Field split of a {marker, payload} word whose payload is dw bits wide.
`define SLICE_MARKER(word, dw)  word[dw]
`define SLICE_PAYLOAD(word, dw) word[(dw)-1:0]

package slice_pkg;

    // Frame alignment tracker states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } track_state_e;

    // Width of the word-in-frame index.
    function automatic int idx_w(input int frame_len);
        return (frame_len < 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

`endif

// File: rtl/slice_frame_unpack_if.sv
// Stream bundle of the slicer: word input side and sliced output side.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid & ready are both high. Once valid is raised it stays high, with its
// payload unchanged, until that transfer; ready may change freely.
interface slice_frame_unpack_if
    import slice_pkg::*;
#(
    parameter int DATA_W    = 6,
    parameter int FRAME_LEN = 16
);
    localparam int IDX_W = idx_w(FRAME_LEN);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W:0]   in_word;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_flag;
    logic [IDX_W-1:0]  out_idx;
    logic              out_sof;

    // Slicer side.
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_data, out_flag, out_idx, out_sof
    );

    // Deserialiser / consumer side.
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_data, out_flag, out_idx, out_sof
    );
endinterface

// File: rtl/slice_skid_buf.sv
// Two-entry skid buffer: one cycle latency, full throughput, registered ready.
module slice_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         push;
    logic         pop;

    assign push      = push_valid & push_ready;
    assign pop       = pop_valid & pop_ready;
    assign pop_valid = (count_q != 2'd0);
    assign pop_data  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and the registered not-full ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count_q    <= 2'd0;
            push_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q    <= count_d;
            push_ready <= (count_d != 2'd2);
        end
    end
endmodule

// File: rtl/slice_frame_unpack.sv
// Registered word slicer with hunt/check/lock frame alignment tracking.
module slice_frame_unpack
    import slice_pkg::*;
#(
    parameter int DATA_W      = 6,
    parameter int FRAME_LEN   = 16,
    parameter int LOCK_FRAMES = 3,
    parameter int ERR_TOL     = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slice_frame_unpack_if.slave  bus,
    output logic                 locked,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     err_cnt,
    output track_state_e         dbg_state
);
    localparam int IDX_W  = idx_w(FRAME_LEN);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int BAD_W  = $clog2(ERR_TOL + 1);
    localparam int BUF_W  = 1 + DATA_W + IDX_W + 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES - 1);
    localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(ERR_TOL);

    track_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc, tag_idx;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [BAD_W-1:0]  bad_q, bad_d, bad_inc;
    logic              accept;
    logic              marker;
    logic              at_start;
    logic              err_d;
    logic              tag_sof;
    logic [BUF_W-1:0]  buf_out;

    assign accept   = bus.in_valid & bus.in_ready;
    assign marker   = `SLICE_MARKER(bus.in_word, DATA_W);
    assign at_start = (idx_q == '0);
    assign idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    assign good_inc = good_q + GOOD_W'(1);
    assign bad_inc  = bad_q + BAD_W'(1);

    // Tracker state register and status outputs; only accepted words move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked    <= (state_d == LOCKED);
            frame_err <= err_d;
            if (err_d && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    // Next tracker state: hunt for a marker, confirm it, then flywheel.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (marker) begin
                        state_d = CHECK;
                        idx_d   = IDX_ONE;
                        good_d  = '0;
                    end
                end
                CHECK: begin
                    idx_d = idx_inc;
                    if (at_start && marker) begin
                        good_d = good_inc;
                        if (good_inc >= GOOD_LOCK) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else if (at_start) begin
                        state_d = HUNT;
                        idx_d   = '0;
                    end else if (marker) begin
                        // Marker out of place: treat it as the new frame start.
                        idx_d  = IDX_ONE;
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    idx_d = idx_inc;
                    if (at_start == marker) begin
                        if (at_start) begin
                            bad_d = '0;
                        end
                    end else begin
                        bad_d = bad_inc;
                        if (bad_inc >= BAD_MAX) begin
                            state_d = HUNT;
                            idx_d   = '0;
                            bad_d   = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Per-word tag and error pulse; sof marks index 0 while the tracker stays aligned.
    always_comb begin
        err_d   = 1'b0;
        tag_idx = idx_q;
        if ((state_q == HUNT) || ((state_q == CHECK) && marker)) begin
            tag_idx = '0;
        end
        if (accept && (state_q != HUNT)) begin
            err_d = (at_start != marker);
        end
        tag_sof = (tag_idx == '0) && (state_d != HUNT);
    end

    assign dbg_state = state_q;

    slice_skid_buf #(
        .W (BUF_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  ({marker, `SLICE_PAYLOAD(bus.in_word, DATA_W), tag_idx, tag_sof}),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (buf_out)
    );

    assign {bus.out_flag, bus.out_data, bus.out_idx, bus.out_sof} = buf_out;
endmodule
